ex_wb_stage: RTL and testbench

- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Registers ALU Result/Zero together with the decoded destination and branch info, and resolves conditional branches from Zero (BEQ/BNE).
- Presents a write request to the register file through a valid/ready handshake; a 2-entry skid buffer keeps throughput at one op per cycle under backpressure.

---
 rtl/ex_wb_stage_if.sv | 42 ++++
 rtl/ex_wb_stage.sv | 120 ++++++++++++
 tb/tb_ex_wb_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_wb_stage_if.sv
// rtl/ex_wb_stage_if.sv - upstream entry, writeback and branch-resolution signals of ex_wb_stage
interface ex_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Upstream (ALU side) entry
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic [REG_AW-1:0] in_rd;
    logic              in_reg_write;
    logic              in_branch;
    logic              in_branch_ne;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_imm;

    // Register-file writeback
    logic              out_valid;
    logic              out_ready;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    // Branch resolution
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    // Drives entries in and accepts writebacks
    modport master (
        output in_valid, in_result, in_zero, in_rd, in_reg_write,
               in_branch, in_branch_ne, in_pc, in_imm, out_ready,
        input  in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target
    );

    // The stage itself
    modport slave (
        input  in_valid, in_result, in_zero, in_rd, in_reg_write,
               in_branch, in_branch_ne, in_pc, in_imm, out_ready,
        output in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target
    );
endinterface

// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - EX->WB stage with 2-entry skid buffer and BEQ/BNE resolution; optional EX_WB_PERF_CNT_EN adds perf counters
module ex_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    ex_wb_stage_if.slave bus
`ifdef EX_WB_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
`endif
);

    // Main entry drives the writeback port; skid absorbs one extra entry
    // so in_ready can be a pure register (no path from out_ready).
    logic              main_valid;
    logic [DATA_W-1:0] main_result;
    logic [REG_AW-1:0] main_rd;
    logic              main_wr;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_result;
    logic [REG_AW-1:0] skid_rd;
    logic              skid_wr;

    logic              accept;
    logic              drain;
    logic              main_free;
    logic              taken;

    assign accept    = bus.in_valid & bus.in_ready;
    assign drain     = main_valid & bus.out_ready;
    // Main can take a new entry this cycle if empty or being emptied
    assign main_free = ~main_valid | drain;
    assign taken     = bus.in_branch & (bus.in_zero ^ bus.in_branch_ne);

    // Occupancy flags; skid always drains into main first to keep FIFO order
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // skid_valid and accept are exclusive because in_ready = !skid_valid
            main_valid <= skid_valid | accept;
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // Payload registers load only on a real load, so they hold under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            main_result <= '0;
            main_rd     <= '0;
            main_wr     <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_wr     <= 1'b0;
        end else if (!flush) begin
            if (main_free && skid_valid) begin
                main_result <= skid_result;
                main_rd     <= skid_rd;
                main_wr     <= skid_wr;
            end else if (main_free && accept) begin
                main_result <= bus.in_result;
                main_rd     <= bus.in_rd;
                main_wr     <= bus.in_reg_write;
            end
            if (!main_free && accept) begin
                skid_result <= bus.in_result;
                skid_rd     <= bus.in_rd;
                skid_wr     <= bus.in_reg_write;
            end
        end
    end

    // Branch resolved at accept; pulse is independent of writeback backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.br_taken  <= 1'b0;
            bus.br_target <= '0;
        end else begin
            bus.br_taken <= accept & taken & ~flush;
            if (accept && taken && !flush) begin
                bus.br_target <= bus.in_pc + bus.in_imm;
            end
        end
    end

`ifdef EX_WB_PERF_CNT_EN
    // Retire/stall counters survive flush, wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (drain) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (main_valid && !bus.out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.wb_en     = main_valid & main_wr & (main_rd != '0);
    assign bus.wb_rd     = main_rd;
    assign bus.wb_data   = main_result;

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb/tb_ex_wb_stage.sv - scoreboard bench for ex_wb_stage
module tb_ex_wb_stage;

    logic clk;
    logic reset;
    logic flush;
    logic mon_en;
    int   n_vec;
    int   n_bad;

    ex_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef EX_WB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
`endif

    ex_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef EX_WB_PERF_CNT_EN
        ,
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
    } exp_t;

    exp_t        sb[$];
    logic        exp_br_taken;
    logic [31:0] exp_br_target;
    logic [31:0] exp_retired;
    logic [31:0] exp_stall;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [31:0] result, input logic [4:0] rd, input logic wr,
                               input logic br, input logic ne, input logic zero,
                               input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid     = 1'b1;
        bus.in_result    = result;
        bus.in_rd        = rd;
        bus.in_reg_write = wr;
        bus.in_branch    = br;
        bus.in_branch_ne = ne;
        bus.in_zero      = zero;
        bus.in_pc        = pc;
        bus.in_imm       = imm;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_wb_en"},     64'(bus.wb_en),     64'd0);
        check({tag, "_wb_rd"},     64'(bus.wb_rd),     64'd0);
        check({tag, "_wb_data"},   64'(bus.wb_data),   64'd0);
        check({tag, "_br_taken"},  64'(bus.br_taken),  64'd0);
        check({tag, "_br_target"}, 64'(bus.br_target), 64'd0);
    endtask

    // Reference model: queue holds the buffered entries in order (main = head)
    always @(negedge clk) begin
        if (mon_en) begin
            int   sz;
            logic acc;
            exp_t e;
            sz = sb.size();
            check("out_valid", 64'(bus.out_valid), 64'(sz > 0));
            check("in_ready",  64'(bus.in_ready),  64'(sz < 2));
            if (sz > 0) begin
                check("wb_data", 64'(bus.wb_data), 64'(sb[0].data));
                check("wb_rd",   64'(bus.wb_rd),   64'(sb[0].rd));
                check("wb_en",   64'(bus.wb_en),   64'(sb[0].en));
            end
            check("br_taken",  64'(bus.br_taken),  64'(exp_br_taken));
            check("br_target", 64'(bus.br_target), 64'(exp_br_target));
`ifdef EX_WB_PERF_CNT_EN
            check("perf_retired", 64'(perf_retired), 64'(exp_retired));
            check("perf_stall",   64'(perf_stall),   64'(exp_stall));
`endif
            if (reset) begin
                sb.delete();
                exp_br_taken  = 1'b0;
                exp_br_target = 32'd0;
                exp_retired   = 32'd0;
                exp_stall     = 32'd0;
            end else begin
                if (sz > 0 && bus.out_ready) begin
                    exp_retired = exp_retired + 32'd1;
                    void'(sb.pop_front());
                end
                if (sz > 0 && !bus.out_ready) begin
                    exp_stall = exp_stall + 32'd1;
                end
                acc = bus.in_valid && (sz < 2);
                exp_br_taken = acc && !flush && bus.in_branch && (bus.in_zero ^ bus.in_branch_ne);
                if (exp_br_taken) begin
                    exp_br_target = bus.in_pc + bus.in_imm;
                end
                if (flush) begin
                    sb.delete();
                end else if (acc) begin
                    e.data = bus.in_result;
                    e.rd   = bus.in_rd;
                    e.en   = bus.in_reg_write && (bus.in_rd != 5'd0);
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic acc;
        clk = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        mon_en = 1'b0;
        n_vec = 0;
        n_bad = 0;
        exp_br_taken = 1'b0;
        exp_br_target = 32'd0;
        exp_retired = 32'd0;
        exp_stall = 32'd0;
        drive_entry(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) cycle();
        mon_en = 1'b1;
        check_reset_values("rst");
        cycle();
        reset = 1'b0;

        // Single entry, latency one cycle
        bus.out_ready = 1'b1;
        drive_entry(32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        bus.in_valid = 1'b0;
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_wb_en",     64'(bus.wb_en),     64'd1);
        check("t1_wb_data",   64'(bus.wb_data),   64'd5);
        check("t1_wb_rd",     64'(bus.wb_rd),     64'd3);
        cycle();
        check("t1_idle", 64'(bus.out_valid), 64'd0);

        // Four entries under 3 cycles of backpressure
        idx = 0;
        for (int k = 0; k < 40 && (idx < 4 || bus.out_valid); k++) begin
            bus.out_ready = (k >= 3);
            if (k == 2) check("t2_in_ready_low", 64'(bus.in_ready), 64'd0);
            if (idx < 4) drive_entry(32'h1000 + 32'(idx), 5'(idx + 1), 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            else bus.in_valid = 1'b0;
            acc = bus.in_ready && (idx < 4);
            cycle();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        check("t2_accepted", 64'(idx), 64'd4);

        // BEQ taken with wrapping target, then BNE not taken
        bus.out_ready = 1'b1;
        drive_entry(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0);
        cycle();
        check("t3_beq_taken",  64'(bus.br_taken),  64'd1);
        check("t3_beq_target", 64'(bus.br_target), 64'h0000_00F0);
        drive_entry(32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h8);
        cycle();
        check("t3_pulse_end",   64'(bus.br_taken),  64'd0);
        check("t3_target_hold", 64'(bus.br_target), 64'h0000_00F0);
        bus.in_valid = 1'b0;
        cycle();
        check("t3_bne_taken", 64'(bus.br_taken), 64'd0);

        // Write to x0
        drive_entry(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        bus.in_valid = 1'b0;
        check("t4_out_valid", 64'(bus.out_valid), 64'd1);
        check("t4_wb_en",     64'(bus.wb_en),     64'd0);
        check("t4_wb_data",   64'(bus.wb_data),   64'hDEAD_BEEF);
        cycle();

        // Flush with one and with two buffered entries, plus an offered taken branch
        for (int nb = 1; nb <= 2; nb++) begin
            bus.out_ready = 1'b0;
            for (int j = 0; j < nb; j++) begin
                drive_entry(32'h2000 + 32'(j), 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                cycle();
            end
            drive_entry(32'h5555_5555, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h40);
            flush = 1'b1;
            cycle();
            flush = 1'b0;
            bus.in_valid = 1'b0;
            check("t5_out_valid", 64'(bus.out_valid), 64'd0);
            check("t5_in_ready",  64'(bus.in_ready),  64'd1);
            check("t5_br_taken",  64'(bus.br_taken),  64'd0);
            bus.out_ready = 1'b1;
            repeat (3) cycle();
        end

        // Random traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            drive_entry($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom, $urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();

`ifdef EX_WB_PERF_CNT_EN
        // Exactly 3 transfers and 2 stall cycles from a fresh reset
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive_entry(32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        bus.out_ready = 1'b0;
        drive_entry(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        drive_entry(32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("perf_retired_3", 64'(perf_retired), 64'd3);
        check("perf_stall_2",   64'(perf_stall),   64'd2);
`endif

        // Reset in the middle of a backed-up stream
        bus.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            drive_entry(32'h3000 + 32'(j), 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            cycle();
        end
        bus.out_ready = 1'b1;
        drive_entry(32'h6666, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h10);
        reset = 1'b1;
        cycle();
        check_reset_values("midrst");
`ifdef EX_WB_PERF_CNT_EN
        check("midrst_perf_retired", 64'(perf_retired), 64'd0);
        check("midrst_perf_stall",   64'(perf_stall),   64'd0);
`endif
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
